// File: rtl/router_pkg.sv
// Constants shared by the router input FSM, router_sync and the router top.
// The helper below turns a destination address into a one-hot FIFO select.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int DEF_TIMEOUT = 30;

  // Address 3 has no FIFO behind it, so it selects nothing.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    sel = '0;
    case (addr)
      2'b00:   sel = 3'b001;
      2'b01:   sel = 3'b010;
      2'b10:   sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_sync_if.sv
// Bundle of FSM-side and FIFO-side signals around router_sync.
// slave is the router_sync view; master is the view of the surrounding logic.
interface router_sync_if;
  import router_pkg::*;

  logic                 detect_add;
  logic [ADDR_W-1:0]    data_in;
  logic                 write_enb_reg;
  logic                 read_enb_0, read_enb_1, read_enb_2;
  logic                 empty_0, empty_1, empty_2;
  logic                 full_0, full_1, full_2;
  logic [NUM_PORTS-1:0] write_enb;
  logic                 fifo_full;
  logic                 vld_out_0, vld_out_1, vld_out_2;
  logic                 soft_reset_0, soft_reset_1, soft_reset_2;

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_sync_timer.sv
// Per-port read timeout: counts consecutive cycles of unread valid data and
// pulses soft_reset for one cycle when the count reaches TIMEOUT.
module router_sync_timer
  import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic cond,
    output logic soft_reset
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping to 0 on the pulse lets a still-stuck FIFO get another pulse TIMEOUT edges later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!cond) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync.sv
// Steers the FSM write strobe to the FIFO named in the packet header, returns
// that FIFO's full flag, and times out FIFOs whose readers stall.
module router_sync
  import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W = 5
) (
    input logic         clock,
    input logic         resetn,
    router_sync_if.slave bus
);

  logic [ADDR_W-1:0]    addr;
  logic [NUM_PORTS-1:0] empty_v;
  logic [NUM_PORTS-1:0] read_v;
  logic [NUM_PORTS-1:0] vld_v;
  logic [NUM_PORTS-1:0] cond_v;
  logic [NUM_PORTS-1:0] soft_v;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= ADDR_INVALID;
    end else if (bus.detect_add) begin
      addr <= bus.data_in;
    end
  end

  // Steering uses the registered addr, so a header-cycle write goes to the previous port.
  always_comb begin
    bus.write_enb = '0;
    if (bus.write_enb_reg) begin
      bus.write_enb = addr_onehot(addr);
    end
  end

  always_comb begin
    bus.fifo_full = 1'b0;
    case (addr)
      2'b00:   bus.fifo_full = bus.full_0;
      2'b01:   bus.fifo_full = bus.full_1;
      2'b10:   bus.fifo_full = bus.full_2;
      default: bus.fifo_full = 1'b0;
    endcase
  end

  assign empty_v = {bus.empty_2, bus.empty_1, bus.empty_0};
  assign read_v  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
  assign vld_v   = ~empty_v;
  assign cond_v  = vld_v & ~read_v;

  assign bus.vld_out_0 = vld_v[0];
  assign bus.vld_out_1 = vld_v[1];
  assign bus.vld_out_2 = vld_v[2];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
    router_sync_timer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .cond      (cond_v[p]),
        .soft_reset(soft_v[p])
    );
  end

  assign bus.soft_reset_0 = soft_v[0];
  assign bus.soft_reset_1 = soft_v[1];
  assign bus.soft_reset_2 = soft_v[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address steering, full mux, valid flags
// and the per-port read timeout with its soft_reset pulse.
module tb_router_sync;

  logic clock;
  logic resetn;
  int n_checks;
  int n_fails;

  router_sync_if bus ();

  router_sync #(
      .TIMEOUT(30),
      .CNT_W  (5)
  ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    bus.read_enb_0    = 1'b0;
    bus.read_enb_1    = 1'b0;
    bus.read_enb_2    = 1'b0;
    bus.empty_0       = 1'b1;
    bus.empty_1       = 1'b1;
    bus.empty_2       = 1'b1;
    bus.full_0        = 1'b0;
    bus.full_1        = 1'b0;
    bus.full_2        = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    resetn = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b1;
    bus.full_1 = 1'b1;
    bus.full_2 = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bus.write_enb !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_write_enb: got %b expected 000", bus.write_enb);
    end
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_fifo_full: got %b expected 0", bus.fifo_full);
    end
    n_checks++;
    if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_soft_reset: got %b expected 000",
               {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    end
    n_checks++;
    if ({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_vld_out: got %b expected 000",
               {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0});
    end
    bus.empty_1 = 1'b0;
    #1;
    n_checks++;
    if ({bus.vld_out_2, bus.vld_out_1, bus.vld_out_0} !== 3'b010) begin
      n_fails++;
      $display("FAIL reset_vld_follows_empty: got %b expected 010",
               {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0});
    end
    drive_idle();
    resetn = 1'b1;
    step();
    // addr stays invalid after release until a header arrives
    bus.write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b000) begin
      n_fails++;
      $display("FAIL post_reset_write_enb: got %b expected 000", bus.write_enb);
    end
    bus.write_enb_reg = 1'b0;
  endtask

  task automatic test_steer_port1();
    logic f0, f1, f2;
    bus.detect_add = 1'b1;
    bus.data_in = 2'b01;
    step();
    bus.detect_add = 1'b0;
    bus.data_in = 2'b00;
    bus.write_enb_reg = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f0 = (i % 2 == 0);
      f1 = (i == 1 || i == 2 || i == 4);
      f2 = (i % 2 == 1);
      bus.full_0 = f0;
      bus.full_1 = f1;
      bus.full_2 = f2;
      #1;
      n_checks++;
      if (bus.write_enb !== 3'b010) begin
        n_fails++;
        $display("FAIL steer1_write_enb[%0d]: got %b expected 010", i, bus.write_enb);
      end
      n_checks++;
      if (bus.fifo_full !== f1) begin
        n_fails++;
        $display("FAIL steer1_fifo_full[%0d]: got %b expected %b", i, bus.fifo_full, f1);
      end
      step();
    end
    bus.write_enb_reg = 1'b0;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b000) begin
      n_fails++;
      $display("FAIL steer1_idle: got %b expected 000", bus.write_enb);
    end
  endtask

  task automatic test_same_cycle_header();
    bus.full_0 = 1'b1;
    bus.full_1 = 1'b0;
    bus.full_2 = 1'b1;
    bus.detect_add = 1'b1;
    bus.data_in = 2'b10;
    bus.write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b010) begin
      n_fails++;
      $display("FAIL same_cycle_old_addr: got %b expected 010", bus.write_enb);
    end
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin
      n_fails++;
      $display("FAIL same_cycle_old_full: got %b expected 0", bus.fifo_full);
    end
    step();
    bus.detect_add = 1'b0;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b100) begin
      n_fails++;
      $display("FAIL same_cycle_new_addr: got %b expected 100", bus.write_enb);
    end
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin
      n_fails++;
      $display("FAIL same_cycle_new_full: got %b expected 1", bus.fifo_full);
    end
    bus.write_enb_reg = 1'b0;
  endtask

  task automatic test_addr_zero_and_invalid();
    bus.detect_add = 1'b1;
    bus.data_in = 2'b00;
    step();
    bus.detect_add = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b1;
    bus.full_1 = 1'b0;
    bus.full_2 = 1'b0;
    #1;
    n_checks++;
    if (bus.write_enb !== 3'b001 || bus.fifo_full !== 1'b1) begin
      n_fails++;
      $display("FAIL addr0: got we=%b full=%b expected we=001 full=1",
               bus.write_enb, bus.fifo_full);
    end
    bus.write_enb_reg = 1'b0;
    bus.detect_add = 1'b1;
    bus.data_in = 2'b11;
    step();
    bus.detect_add = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b1;
    bus.full_1 = 1'b1;
    bus.full_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.write_enb !== 3'b000 || bus.fifo_full !== 1'b0) begin
        n_fails++;
        $display("FAIL addr3_dropped[%0d]: got we=%b full=%b expected we=000 full=0",
                 i, bus.write_enb, bus.fifo_full);
      end
      step();
    end
    drive_idle();
  endtask

  task automatic test_timeout_port2();
    bus.empty_2 = 1'b0;
    for (int e = 1; e <= 29; e++) begin
      step();
      n_checks++;
      if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
        n_fails++;
        $display("FAIL to2_early[%0d]: got %b expected 000", e,
                 {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
      end
    end
    step();
    n_checks++;
    if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b100) begin
      n_fails++;
      $display("FAIL to2_pulse: got %b expected 100",
               {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    end
    bus.empty_2 = 1'b1;
    for (int e = 0; e < 35; e++) begin
      step();
      n_checks++;
      if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
        n_fails++;
        $display("FAIL to2_after[%0d]: got %b expected 000", e,
                 {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
      end
    end
  endtask

  task automatic test_read_restart_port0();
    bus.empty_0 = 1'b0;
    for (int e = 1; e <= 58; e++) begin
      bus.read_enb_0 = (e == 29);
      step();
      n_checks++;
      if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
        n_fails++;
        $display("FAIL rd0_no_pulse[%0d]: got %b expected 000", e,
                 {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
      end
    end
    bus.read_enb_0 = 1'b0;
    step();
    n_checks++;
    if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b001) begin
      n_fails++;
      $display("FAIL rd0_pulse: got %b expected 001",
               {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    end
    bus.empty_0 = 1'b1;
    step();
    n_checks++;
    if (bus.soft_reset_0 !== 1'b0) begin
      n_fails++;
      $display("FAIL rd0_one_cycle: got %b expected 0", bus.soft_reset_0);
    end
  endtask

  task automatic test_reset_mid_count_port1();
    bus.empty_1 = 1'b0;
    repeat (20) step();
    resetn = 1'b0;
    bus.write_enb_reg = 1'b1;
    bus.full_0 = 1'b1;
    bus.full_1 = 1'b1;
    bus.full_2 = 1'b1;
    #1;
    n_checks++;
    if (bus.soft_reset_1 !== 1'b0 || bus.write_enb !== 3'b000 || bus.fifo_full !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_outputs: got sr1=%b we=%b full=%b expected 0/000/0",
               bus.soft_reset_1, bus.write_enb, bus.fifo_full);
    end
    step();
    step();
    bus.write_enb_reg = 1'b0;
    bus.full_0 = 1'b0;
    bus.full_1 = 1'b0;
    bus.full_2 = 1'b0;
    resetn = 1'b1;
    for (int pulse = 0; pulse < 2; pulse++) begin
      for (int e = 1; e <= 29; e++) begin
        step();
        n_checks++;
        if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b000) begin
          n_fails++;
          $display("FAIL midrst_early[%0d.%0d]: got %b expected 000", pulse, e,
                   {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
        end
      end
      step();
      n_checks++;
      if ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} !== 3'b010) begin
        n_fails++;
        $display("FAIL midrst_pulse[%0d]: got %b expected 010", pulse,
                 {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
      end
    end
    bus.empty_1 = 1'b1;
    step();
    n_checks++;
    if (bus.soft_reset_1 !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_end: got %b expected 0", bus.soft_reset_1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    resetn = 1'b0;
    drive_idle();
    @(negedge clock);
    test_reset();
    test_steer_port1();
    test_same_cycle_header();
    test_addr_zero_and_invalid();
    test_timeout_port2();
    test_read_restart_port0();
    test_reset_mid_count_port1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/router_sync.md
# router_sync

Synchroniser between the router's input control FSM and the three output FIFOs (router_fifo ×3).
- Latches the 2-bit destination address from each packet header and steers the FSM's single write strobe to the addressed FIFO.
- Returns that FIFO's full flag to the FSM.
- Drives per-port valid flags to the downstream readers.
- Issues a one-cycle soft_reset to any FIFO whose destination fails to read within a timeout.

## Interface
- TIMEOUT, 30: consecutive unread-valid cycles before that port's soft_reset fires (≥2)
- CNT_W, 5: timeout counter width; 2**CNT_W ≥ TIMEOUT
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- detect_add  in  1  from FSM; header byte present, latch address
- data_in  in  2  address field (header bits [1:0])
- write_enb_reg  in  1  from FSM; write strobe for current packet byte
- read_enb_0/1/2  in  1  downstream read strobes
- empty_0/1/2  in  1  FIFO empty flags
- full_0/1/2  in  1  FIFO full flags
- write_enb  out  3  one-hot FIFO write enables (bit n → FIFO n)
- fifo_full  out  1  full flag of addressed FIFO
- vld_out_0/1/2  out  1  port has data
- soft_reset_0/1/2  out  1  registered one-cycle FIFO soft reset

## Operation
- Address register addr[1:0]: on rising edge with detect_add=1, addr ← data_in; otherwise holds. Reset value 2'b11 (invalid).
- write_enb (combinational): write_enb_reg=0 → 3'b000; else addr 00→001, 01→010, 10→100, 11→000. Bytes to address 3 are dropped silently.
- fifo_full (combinational): 00→full_0, 01→full_1, 10→full_2, 11→0.
- vld_out_n = ~empty_n (combinational, no latency).
- Per-port timer, identical ×3. Condition: cond_n = vld_out_n & ~read_enb_n, sampled each rising edge.
  - cond_n=0 → cnt_n ← 0, soft_reset_n ← 0.
  - cond_n=1 and cnt_n < TIMEOUT-1 → cnt_n ← cnt_n+1, soft_reset_n ← 0.
  - cond_n=1 and cnt_n = TIMEOUT-1 → cnt_n ← 0, soft_reset_n ← 1.
- Ports are independent; several soft_resets may pulse in the same cycle.

## Timing
- Reset (async, any time, including mid-packet or mid-count): addr=2'b11, all cnt=0, soft_reset_0/1/2=0. Consequently write_enb=000 and fifo_full=0 during and after reset until the next header. vld_out follows empty_n even during reset.
- Address latency: addr is valid from the edge that samples detect_add. write_enb/fifo_full reflect the new addr in the following cycle. If detect_add and write_enb_reg are high in the same cycle, steering uses the previous addr.
- soft_reset_n rises after the TIMEOUT-th consecutive sampling edge with cond_n=1 and stays high exactly one cycle.
  - One cycle with read_enb_n=1 or empty_n=1 restarts the count from 0.
  - If cond_n persists after the pulse, (the FIFO failed to empty), a further pulse follows TIMEOUT edges later.
- No counter overflow: cnt never exceeds TIMEOUT-1.

## Structure
- Shared package router_pkg holds: NUM_PORTS=3; ADDR_W=2; ADDR_INVALID=2'b11; default TIMEOUT=30. The FSM and router top use the same constants.
- One sub-module, router_sync_timer: per-port counter plus soft_reset register, parameterised TIMEOUT/CNT_W, instantiated 3× by generate.
- Address decode and full mux stay in router_sync.

## Test plan
- Reset → write_enb=000, fifo_full=0, soft_reset_*=0. With empty_*=1, vld_out_*=0.
- detect_add=1, data_in=01 for one edge, then write_enb_reg=1 for 6 cycles → write_enb=010 for those 6 cycles. fifo_full tracks full_1; toggling full_0/full_2 has no effect.
- data_in=11 header, then write_enb_reg=1 → write_enb=000, fifo_full=0 even with all full_*=1.
- empty_2=0, read_enb_2=0 held → soft_reset_2 high for exactly one cycle after the 30th edge, others stay 0. Drive empty_2=1 next cycle → no further pulse.
- empty_0=0; read_enb_0=1 for one cycle at edge 29, then 0 → no pulse at 30. Pulse occurs 30 edges after the read.
- resetn low mid-count (cnt_1=20) → soft_reset_1=0, count restarts. With condition held after release, the pulse comes 30 edges after release.
